// File: rtl/store_write_arbiter.sv
// store_write_arbiter: round-robin arbitration of two store ports, alignment check,
// byte-lane formatting and a small FIFO draining onto the data-memory write port.
module store_write_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WR_EN_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  input  logic [1:0]             req0_size,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic [1:0]             req1_size,
  input  logic                   mem_gnt,
  output logic [WR_EN_WIDTH-1:0] wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   misalign_err,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic                   err_src,
  output logic                   busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic                   last_grant, sel1, full, xfer, mis, push, pop;
  logic [PW:0]            count;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  data, fdata;
  logic [1:0]             size;
  logic [WR_EN_WIDTH-1:0] base, fen;
  logic [WR_EN_WIDTH-1:0] fifo_en   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  // last_grant holds the port of the last transfer; on a tie the other port wins
  assign sel1       = req1_valid & (~req0_valid | ~last_grant);
  assign full       = count[PW];
  assign req0_ready = req0_valid & ~sel1 & ~full;
  assign req1_ready = sel1 & ~full;
  assign xfer       = req0_ready | req1_ready;
  assign addr       = sel1 ? req1_addr : req0_addr;
  assign data       = sel1 ? req1_data : req0_data;
  assign size       = sel1 ? req1_size : req0_size;
  assign mis        = (size == 2'd3) | (size == 2'd1 & addr[0]) | (size == 2'd2 & |addr[1:0]);
  assign base       = size == 2'd0 ? WR_EN_WIDTH'(4'b0001) : size == 2'd1 ? WR_EN_WIDTH'(4'b0011) : WR_EN_WIDTH'(4'b1111);
  assign fen        = base << addr[1:0];
  assign fdata      = size == 2'd0 ? {4{data[7:0]}} : size == 2'd1 ? {2{data[15:0]}} : data;
  assign push       = xfer & ~mis;
  assign pop        = |count & mem_gnt;
  assign busy       = |count | |wr_en;
  always_ff @(posedge clk)
    if (push) begin
      fifo_en[wr_ptr]   <= fen;
      fifo_addr[wr_ptr] <= {addr[ADDR_WIDTH-1:2], 2'b00};
      fifo_data[wr_ptr] <= fdata;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant   <= 1'b1;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      wr_en        <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
      err_src      <= 1'b0;
    end else begin
      last_grant   <= xfer ? sel1 : last_grant;
      count        <= count + (PW+1)'(push) - (PW+1)'(pop);
      wr_ptr       <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_en        <= pop ? fifo_en[rd_ptr] : '0;
      wr_addr      <= pop ? fifo_addr[rd_ptr] : wr_addr;
      wr_data      <= pop ? fifo_data[rd_ptr] : wr_data;
      misalign_err <= xfer & mis;
      err_addr     <= xfer & mis ? addr : err_addr;
      err_src      <= xfer & mis ? sel1 : err_src;
    end
endmodule
